// File: rtl/uart_pkg.sv
// Purpose: shared receive-state enum, parity encodings and tick-divisor helper for uart_rx_cfg.
// Latency: none, types and constants only.
// Backpressure: none.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clocks per oversample tick, rounded to nearest and never below 1.
    function automatic int calc_tick(input int clock_rate, input int baud_rate,
                                     input int oversample);
        int den;
        int q;
        den = baud_rate * oversample;
        q   = (clock_rate + den / 2) / den;
        return (q < 1) ? 1 : q;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Purpose: serial line in and received-frame result out of uart_rx_cfg.
// Latency: none, wiring only.
// Backpressure: none; results are strobed and held until the next frame.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_Rx_Data;
    logic [DATA_BITS-1:0] o_Rx_Byte;
    logic                 o_Rx_Done;
    logic                 o_Rx_Frame_Err;
    logic                 o_Rx_Parity_Err;
    logic                 o_Rx_Busy;

    // Receiver side
    modport master (
        input  i_Rx_Data,
        output o_Rx_Byte, o_Rx_Done, o_Rx_Frame_Err, o_Rx_Parity_Err, o_Rx_Busy
    );

    // Line driver / byte consumer side
    modport slave (
        output i_Rx_Data,
        input  o_Rx_Byte, o_Rx_Done, o_Rx_Frame_Err, o_Rx_Parity_Err, o_Rx_Busy
    );
endinterface

// File: rtl/uart_os_tick.sv
// Purpose: free-running divider emitting a 1-clk tick every TICK clocks, held at zero by restart.
// Latency: first tick TICK clocks after restart drops.
// Backpressure: none.
module uart_os_tick #(
    parameter int TICK = 14
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);
    localparam int             CW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (restart || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = !restart && (cnt == LAST);
endmodule

// File: rtl/uart_rx_cfg.sv
// Purpose: oversampling UART receiver with majority voting; parity checker compiled in with UART_RX_PARITY_EN.
// Latency: falling start edge to o_Rx_Done = 2 + TICK*(OS/2+2 + OS*(DATA_BITS+P+STOP_BITS)) clk.
// Backpressure: none; o_Rx_Done is a 1-clk strobe, byte and error flags hold until the next strobe.
module uart_rx_cfg #(
    parameter int CLOCK_RATE    = 25000000,
    parameter int BAUD_RATE     = 115200,
    parameter int RX_OVERSAMPLE = 16,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int PARITY        = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    uart_rx_cfg_if.master rx
);
    import uart_pkg::*;

    localparam int            TICK   = calc_tick(CLOCK_RATE, BAUD_RATE, RX_OVERSAMPLE);
    localparam int            TW     = $clog2(RX_OVERSAMPLE);
    localparam logic [TW-1:0] T_S0   = TW'(RX_OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(RX_OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC  = TW'(RX_OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(RX_OVERSAMPLE - 1);
    localparam logic [3:0]    D_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    S_LAST = 4'(STOP_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_ON  = (PARITY != PAR_NONE);
    localparam bit PAR_SEL = (PARITY == PAR_ODD);
`else
    // Frames never carry a parity bit in this build.
    localparam bit PAR_ON  = 1'b0 && (PARITY != PAR_NONE);
`endif

    rx_state_e            state, state_nxt;
    logic                 rx_meta, rx_sync, rx_prev, armed;
    logic                 tick, decide, start_det, frame_end, bit_val;
    logic [TW-1:0]        tick_cnt;
    logic [3:0]           bit_cnt;
    logic                 s0, s1;
    logic [DATA_BITS-1:0] shreg, byte_q;
    logic                 fe_pend, done_q, fe_q;
`ifdef UART_RX_PARITY_EN
    logic                 pe_pend, pe_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx.i_Rx_Data;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // A bad stop bit (or break) disarms until the line has been seen high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            armed <= 1'b1;
        else if (frame_end && (fe_pend || !bit_val))
            armed <= 1'b0;
        else if (rx_sync)
            armed <= 1'b1;
    end

    uart_os_tick #(.TICK(TICK)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (state == RX_IDLE),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            s0       <= 1'b0;
            s1       <= 1'b0;
        end else if (state == RX_IDLE) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + TW'(1);
            if (tick_cnt == T_S0) s0 <= rx_sync;
            if (tick_cnt == T_S1) s1 <= rx_sync;
        end
    end

    assign start_det = (state == RX_IDLE) && armed && rx_prev && !rx_sync;
    assign decide    = tick && (tick_cnt == T_DEC);
    assign bit_val   = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= RX_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        frame_end = 1'b0;
        case (state)
            RX_IDLE:  if (start_det) state_nxt = RX_START;
            RX_START: if (decide) state_nxt = bit_val ? RX_IDLE : RX_DATA;
            RX_DATA:  if (decide && bit_cnt == D_LAST)
                          state_nxt = PAR_ON ? RX_PARITY : RX_STOP;
`ifdef UART_RX_PARITY_EN
            RX_PARITY: if (decide) state_nxt = RX_STOP;
`endif
            RX_STOP: begin
                if (decide && bit_cnt == S_LAST) begin
                    state_nxt = RX_IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            fe_pend <= 1'b0;
            byte_q  <= '0;
            done_q  <= 1'b0;
            fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_pend <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state == RX_IDLE) begin
                bit_cnt <= '0;
                fe_pend <= 1'b0;
`ifdef UART_RX_PARITY_EN
                pe_pend <= 1'b0;
`endif
            end else if (decide) begin
                case (state)
                    RX_DATA: begin
                        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                        bit_cnt <= (bit_cnt == D_LAST) ? 4'd0 : bit_cnt + 4'd1;
                    end
`ifdef UART_RX_PARITY_EN
                    RX_PARITY: pe_pend <= (^shreg) ^ bit_val ^ PAR_SEL;
`endif
                    RX_STOP: begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (!bit_val) fe_pend <= 1'b1;
                        if (frame_end) begin
                            byte_q <= shreg;
                            fe_q   <= fe_pend | !bit_val;
                            done_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            pe_q   <= pe_pend;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx.o_Rx_Byte      = byte_q;
    assign rx.o_Rx_Done      = done_q;
    assign rx.o_Rx_Frame_Err = fe_q;
    assign rx.o_Rx_Busy      = (state != RX_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx.o_Rx_Parity_Err = pe_q;
`else
    assign rx.o_Rx_Parity_Err = PAR_ON;
`endif
endmodule
